// File: rtl/skeleton_host_pkg.sv
// skeleton_host_pkg: shared opcodes, response bytes and FSM state encoding
package skeleton_host_pkg;
  localparam logic [1:0] OP_WRITE     = 2'b00;
  localparam logic [1:0] OP_START     = 2'b01;
  localparam logic [1:0] OP_READ_RES  = 2'b10;
  localparam logic [1:0] OP_READ_HEAD = 2'b11;
  localparam logic [7:0] RSP_ACK = 8'hA5;
  localparam logic [7:0] RSP_ERR = 8'hEE;
  typedef enum logic [2:0] {
    S_IDLE, S_GET_HI, S_GET_LO, S_WRITE, S_TRIG, S_WAIT_RDY, S_LOAD_TX, S_TX
  } state_t;
endpackage

// File: rtl/skeleton_host_txser.sv
// skeleton_host_txser: MSB-first response shifter with valid/ready byte handshake
module skeleton_host_txser (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_cnt,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        done
);
  logic [31:0] sr_q, sr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        xfer;
  assign tx_valid = cnt_q != '0;
  assign tx_data  = sr_q[31:24];
  assign xfer     = tx_valid && tx_ready;
  assign done     = xfer && cnt_q == 3'd1;
  // shift out one byte per accepted handshake; a load replaces everything
  always_comb begin
    sr_d  = load ? load_data : xfer ? {sr_q[23:0], 8'h00} : sr_q;
    cnt_d = load ? load_cnt : xfer ? cnt_q - 3'd1 : cnt_q;
  end
  // register shifter state; reset withdraws any pending byte
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/skeleton_host_ctrl.sv
// skeleton_host_ctrl: turns UART command bytes into skeleton bus cycles and byte responses
module skeleton_host_ctrl
  import skeleton_host_pkg::*;
#(
  parameter int BITWIDTH_SYS  = 16,
  parameter int BITWIDTH_ADR  = 6,
  parameter int BITWIDTH_HEAD = 32,
  parameter int TIMEOUT_CYC   = 1024
) (
  input  logic                      CLK_SYS,
  input  logic                      RST,
  input  logic                      RX_VALID,
  input  logic [7:0]                RX_DATA,
  input  logic                      TX_READY,
  output logic                      TX_VALID,
  output logic [7:0]                TX_DATA,
  output logic                      SKEL_EN,
  output logic                      SKEL_RnW,
  output logic [BITWIDTH_ADR-1:0]   SKEL_ADR,
  output logic [BITWIDTH_SYS-1:0]   SKEL_DATA_IN,
  output logic                      SKEL_TRGG_START_CALC,
  input  logic [BITWIDTH_SYS-1:0]   SKEL_DATA_OUT,
  input  logic [BITWIDTH_HEAD-7:0]  SKEL_DATA_HEAD,
  input  logic                      SKEL_RDY,
  output logic                      BUSY,
  output logic                      OVERRUN
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  state_t                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [7:0]              rsp_q, rsp_d;
  logic [BITWIDTH_ADR-1:0] adr_q, adr_d;
  logic [BITWIDTH_SYS-1:0] din_q, din_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    rnw_q, rnw_d, trig_q, trig_d, ovr_q, ovr_d;
  logic                    load, done;
  logic [31:0]             load_data;
  logic [2:0]              load_cnt;
  // next-state logic; bus strobes are registered from the next state so they line up with it
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rsp_d   = rsp_q;
    adr_d   = adr_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q | (RX_VALID && !(state_q inside {S_IDLE, S_GET_HI, S_GET_LO}));
    case (state_q)
      S_IDLE: if (RX_VALID) begin
        op_d    = RX_DATA[7:6];
        adr_d   = RX_DATA[BITWIDTH_ADR-1:0];
        state_d = RX_DATA[7:6] == OP_WRITE ? S_GET_HI : RX_DATA[7:6] == OP_START ? S_TRIG : S_LOAD_TX;
      end
      S_GET_HI: if (RX_VALID) begin
        din_d[15:8] = RX_DATA;
        state_d     = S_GET_LO;
      end
      S_GET_LO: if (RX_VALID) begin
        din_d[7:0] = RX_DATA;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        rsp_d   = RSP_ACK;
        state_d = S_LOAD_TX;
      end
      S_TRIG: begin
        cnt_d   = '0;
        state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: if (SKEL_RDY && cnt_q != '0) begin
        rsp_d   = RSP_ACK;
        state_d = S_LOAD_TX;
      end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
        rsp_d   = RSP_ERR;
        state_d = S_LOAD_TX;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      S_LOAD_TX: state_d = S_TX;
      S_TX:      state_d = done ? S_IDLE : S_TX;
      default:   state_d = S_IDLE;
    endcase
    rnw_d  = state_d != S_WRITE;
    trig_d = state_d == S_TRIG;
  end
  // FSM state and registered bus outputs
  always_ff @(posedge CLK_SYS) begin
    if (RST) begin
      state_q <= S_IDLE;
      op_q    <= OP_WRITE;
      rsp_q   <= RSP_ACK;
      adr_q   <= '0;
      din_q   <= '0;
      cnt_q   <= '0;
      rnw_q   <= 1'b1;
      trig_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rsp_q   <= rsp_d;
      adr_q   <= adr_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
      rnw_q   <= rnw_d;
      trig_q  <= trig_d;
      ovr_q   <= ovr_d;
    end
  end
  assign load      = state_q == S_LOAD_TX;
  assign load_data = op_q == OP_READ_RES ? {SKEL_DATA_OUT, 16'h0000} :
                     op_q == OP_READ_HEAD ? 32'(SKEL_DATA_HEAD) : {rsp_q, 24'h000000};
  assign load_cnt  = op_q == OP_READ_RES ? 3'd2 : op_q == OP_READ_HEAD ? 3'd4 : 3'd1;
  skeleton_host_txser u_txser (
    .clk       (CLK_SYS),
    .rst       (RST),
    .load      (load),
    .load_data (load_data),
    .load_cnt  (load_cnt),
    .tx_ready  (TX_READY),
    .tx_valid  (TX_VALID),
    .tx_data   (TX_DATA),
    .done      (done)
  );
  assign SKEL_EN              = 1'b1;
  assign SKEL_RnW             = rnw_q;
  assign SKEL_ADR             = adr_q;
  assign SKEL_DATA_IN         = din_q;
  assign SKEL_TRGG_START_CALC = trig_q;
  assign BUSY                 = state_q != S_IDLE;
  assign OVERRUN              = ovr_q;
endmodule

// File: tb/tb_skeleton_host_ctrl.sv
// tb_skeleton_host_ctrl: directed and random command traffic against a command-level model
module tb_skeleton_host_ctrl;
  import skeleton_host_pkg::*;
  localparam int TO = 1024;
  logic        CLK_SYS = 1'b0, RST = 1'b1, RX_VALID = 1'b0, TX_READY = 1'b0, SKEL_RDY = 1'b1;
  logic [7:0]  RX_DATA = 8'h00, TX_DATA;
  logic        TX_VALID, SKEL_EN, SKEL_RnW, SKEL_TRGG_START_CALC, BUSY, OVERRUN;
  logic [5:0]  SKEL_ADR;
  logic [15:0] SKEL_DATA_IN, SKEL_DATA_OUT = 16'h0000;
  logic [25:0] SKEL_DATA_HEAD = 26'h0;
  int          n_tests = 0, n_fail = 0;
  int          ready_mode = 0, rdy_mode = 0, trig_cnt = 0, t0 = 0, exp_trig = 0;
  logic [15:0] mem [64];
  logic [15:0] m_mem [64];
  logic [15:0] m_res = 16'h0000;
  logic        trig_prev = 1'b0, stall_prev = 1'b0;
  logic [7:0]  stall_data = 8'h00;
  logic [7:0]  tx_log [$], exp_tx [$];
  logic [21:0] wr_log [$], exp_wr [$];

  skeleton_host_ctrl dut (
    .CLK_SYS(CLK_SYS), .RST(RST), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA),
    .TX_READY(TX_READY), .TX_VALID(TX_VALID), .TX_DATA(TX_DATA),
    .SKEL_EN(SKEL_EN), .SKEL_RnW(SKEL_RnW), .SKEL_ADR(SKEL_ADR), .SKEL_DATA_IN(SKEL_DATA_IN),
    .SKEL_TRGG_START_CALC(SKEL_TRGG_START_CALC), .SKEL_DATA_OUT(SKEL_DATA_OUT),
    .SKEL_DATA_HEAD(SKEL_DATA_HEAD), .SKEL_RDY(SKEL_RDY), .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  always #5 CLK_SYS = ~CLK_SYS;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // skeleton stand-in (multiplier of the upper bytes of words 0 and 1) plus bus/TX monitors
  always @(negedge CLK_SYS) begin
    int a, b;
    TX_READY = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'b0 :
               ready_mode == 2 ? ~TX_READY : 1'($urandom_range(0, 1));
    SKEL_RDY = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
    if (RST) begin
      stall_prev = 1'b0;
      trig_prev  = 1'b0;
    end else begin
      if (stall_prev) chk("tx_hold", {23'h0, TX_VALID, TX_DATA}, {23'h0, 1'b1, stall_data});
      stall_prev = TX_VALID && !TX_READY;
      stall_data = TX_DATA;
      if (TX_VALID && TX_READY) tx_log.push_back(TX_DATA);
      if (!SKEL_RnW) begin
        wr_log.push_back({SKEL_ADR, SKEL_DATA_IN});
        mem[SKEL_ADR] = SKEL_DATA_IN;
      end
      if (SKEL_TRGG_START_CALC) trig_cnt++;
      if (trig_prev && !SKEL_TRGG_START_CALC) begin
        a = int'(mem[0][15:8]);
        b = int'(mem[1][15:8]);
        SKEL_DATA_OUT = 16'(a * b);
      end
      trig_prev = SKEL_TRGG_START_CALC;
    end
  end

  task automatic send(input logic [7:0] v);
    @(negedge CLK_SYS);
    RX_VALID = 1'b1;
    RX_DATA  = v;
    @(negedge CLK_SYS);
    RX_VALID = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_txv"}, TX_VALID, 0);
    chk({tag, "_txd"}, TX_DATA, 0);
    chk({tag, "_en"}, SKEL_EN, 1);
    chk({tag, "_rnw"}, SKEL_RnW, 1);
    chk({tag, "_adr"}, SKEL_ADR, 0);
    chk({tag, "_din"}, SKEL_DATA_IN, 0);
    chk({tag, "_trg"}, SKEL_TRGG_START_CALC, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_ovr"}, OVERRUN, 0);
  endtask

  task automatic begin_cmd();
    tx_log.delete();
    wr_log.delete();
    exp_tx.delete();
    exp_wr.delete();
    t0 = trig_cnt;
    exp_trig = 0;
  endtask

  // command-level reference: what the skeleton sees and what bytes come back
  task automatic model(input logic [1:0] op, input logic [5:0] adr, input logic [15:0] d,
                       input logic [25:0] head, input bit rdy_ok);
    int a, b;
    case (op)
      OP_WRITE: begin
        m_mem[adr] = d;
        exp_wr.push_back({adr, d});
        exp_tx.push_back(RSP_ACK);
      end
      OP_START: begin
        a = int'(m_mem[0][15:8]);
        b = int'(m_mem[1][15:8]);
        m_res = 16'(a * b);
        exp_trig = 1;
        exp_tx.push_back(rdy_ok ? RSP_ACK : RSP_ERR);
      end
      OP_READ_RES: begin
        exp_tx.push_back(m_res[15:8]);
        exp_tx.push_back(m_res[7:0]);
      end
      default: for (int i = 3; i >= 0; i--) exp_tx.push_back(8'(32'(head) >> (8 * i)));
    endcase
  endtask

  task automatic check_logs(input string tag);
    int k = 0;
    while (BUSY && k < 4 * TO) begin
      @(negedge CLK_SYS);
      k++;
    end
    chk({tag, "_idle"}, BUSY, 0);
    @(negedge CLK_SYS);
    chk({tag, "_txn"}, tx_log.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++) chk({tag, "_tx"}, tx_log[i], exp_tx[i]);
    chk({tag, "_wrn"}, wr_log.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) chk({tag, "_wr"}, wr_log[i], exp_wr[i]);
    chk({tag, "_trig"}, trig_cnt - t0, exp_trig);
  endtask

  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [5:0] adr,
                        input logic [15:0] d, input logic [25:0] head);
    begin_cmd();
    model(op, adr, d, head, 1'b1);
    SKEL_DATA_HEAD = head;
    send({op, adr});
    if (op == OP_WRITE) begin
      send(d[15:8]);
      send(d[7:0]);
    end
    check_logs(tag);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 64; i++) begin
      mem[i]   = 16'h0;
      m_mem[i] = 16'h0;
    end
    repeat (3) @(negedge CLK_SYS);
    check_reset("rst");
    RST = 1'b0;
    // write with latency: RnW low one cycle after the last operand, TX_VALID three cycles after
    begin_cmd();
    model(OP_WRITE, 6'd5, 16'h1234, 26'h0, 1'b1);
    send(8'h05);
    send(8'h12);
    send(8'h34);
    chk("wr_rnw", SKEL_RnW, 0);
    chk("wr_adr", SKEL_ADR, 5);
    chk("wr_din", SKEL_DATA_IN, 16'h1234);
    @(negedge CLK_SYS);
    chk("wr_rnw_end", SKEL_RnW, 1);
    chk("wr_txv_early", TX_VALID, 0);
    @(negedge CLK_SYS);
    chk("wr_txv", TX_VALID, 1);
    chk("wr_ack", TX_DATA, RSP_ACK);
    check_logs("wr");
    chk("wr_hold_din", SKEL_DATA_IN, 16'h1234);
    // multiplier: 3 * 4
    do_cmd("wa", OP_WRITE, 6'd0, 16'h0300, 26'h0);
    do_cmd("wb", OP_WRITE, 6'd1, 16'h0400, 26'h0);
    do_cmd("start", OP_START, 6'd0, 16'h0, 26'h0);
    begin_cmd();
    model(OP_READ_RES, 6'd0, 16'h0, 26'h0, 1'b1);
    send(8'h80);
    chk("rd_txv_early", TX_VALID, 0);
    @(negedge CLK_SYS);
    chk("rd_txv", TX_VALID, 1);
    check_logs("rd");
    // timeout: command cycle, TRIG, TO cycles waiting, LOAD_TX, then TX
    rdy_mode = 1;
    begin_cmd();
    model(OP_START, 6'd0, 16'h0, 26'h0, 1'b0);
    send(8'h40);
    k = 1;
    while (!TX_VALID && k < TO + 50) begin
      @(negedge CLK_SYS);
      k++;
    end
    chk("to_lat", k, TO + 3);
    chk("to_err", TX_DATA, RSP_ERR);
    chk("to_busy", BUSY, 1);
    @(negedge CLK_SYS);
    chk("to_busy_fall", BUSY, 0);
    check_logs("to");
    rdy_mode = 0;
    // header with stalling receiver
    ready_mode = 2;
    do_cmd("head", OP_READ_HEAD, 6'd0, 16'h0, 26'h1234567);
    // overrun while the response is stalled
    chk("ovr_pre", OVERRUN, 0);
    ready_mode = 1;
    begin_cmd();
    model(OP_READ_RES, 6'd0, 16'h0, 26'h0, 1'b1);
    send(8'h80);
    k = 0;
    while (!TX_VALID && k < 20) begin
      @(negedge CLK_SYS);
      k++;
    end
    send(8'h99);
    chk("ovr_set", OVERRUN, 1);
    ready_mode = 0;
    check_logs("ovr");
    do_cmd("ovr_next", OP_READ_HEAD, 6'd3, 16'h0, 26'h2ABCDEF);
    chk("ovr_sticky", OVERRUN, 1);
    // reset mid-command
    begin_cmd();
    send(8'h00);
    send(8'hAB);
    RST = 1'b1;
    @(negedge CLK_SYS);
    check_reset("mid");
    RST = 1'b0;
    chk("mid_nowr", wr_log.size(), 0);
    do_cmd("mid_wr", OP_WRITE, 6'd0, 16'h1122, 26'h0);
    // random traffic with random receiver and ready behaviour
    ready_mode = 3;
    rdy_mode   = 2;
    for (int n = 0; n < 40; n++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      do_cmd("rnd", op, op == OP_WRITE ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63)),
             16'($urandom), 26'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d checks failed", n_fail, n_tests);
    $fatal(1, "watchdog");
  end
endmodule
